// File: rtl/self_test_sort_tx.sv
// Sorting self-test buffer: insertion-sorts up to DEPTH words by key, then dumps them
// in parallel or as serial frames. Define SELF_TEST_PARITY_EN to add an even-parity bit per frame.
module self_test_sort_tx #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int KEY_LSB = 21,
   parameter int KEY_W   = 5,
   parameter int BIT_DIV = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       f_layer,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       sort_finish,
   output logic [DATA_W-1:0]          data_out,
   output logic                       out_valid,
   output logic                       tx_out,
   output logic                       tx_busy,
   output logic [2:0]                 dbg_state
);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int BIT_W = $clog2(DATA_W);
   localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W-1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV-1);

   typedef enum logic [2:0] {
      ST_FILL, ST_DONE, ST_DUMP_PAR, ST_TX_START, ST_TX_DATA, ST_TX_PARITY, ST_TX_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] ins_mem [DEPTH];
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0]  ins_pos, cnt_next;
   logic [DATA_W-1:0] out_word;
   logic              accept, div_end, last_word, tx_line;

   // Stable insertion: the new word lands after every held entry whose key is <= its key.
   always_comb begin
      ins_pos = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < count_q && mem_q[i][KEY_LSB +: KEY_W] <= data_in[KEY_LSB +: KEY_W])
            ins_pos = ins_pos + CNT_ONE;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < ins_pos)       ins_mem[i] = mem_q[i];
         else if (CNT_W'(i) == ins_pos) ins_mem[i] = data_in;
         else                           ins_mem[i] = mem_q[(i > 0) ? i-1 : 0];
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      mem_d       = mem_q;
      idx_d       = idx_q;
      bit_d       = bit_q;
      div_d       = div_q;
      in_ready    = 1'b0;
      sort_finish = 1'b0;
      out_valid   = 1'b0;
      tx_busy     = 1'b0;
      tx_line     = 1'b1;
      accept      = 1'b0;
      cnt_next    = count_q;
      out_word    = mem_q[idx_q];
      div_end     = (div_q == DIV_LAST);
      last_word   = ((CNT_W'(idx_q) + CNT_ONE) == count_q);

      case (state_q)
         ST_FILL: begin
            in_ready = (count_q < DEPTH_C);
            accept   = in_valid & in_ready;
            if (accept) begin
               mem_d    = ins_mem;
               cnt_next = count_q + CNT_ONE;
            end
            count_d = cnt_next;
            idx_d   = '0;
            bit_d   = '0;
            div_d   = '0;
            if (cnt_next == DEPTH_C || (flush && cnt_next != '0)) state_d = ST_DONE;
         end
         ST_DONE: begin
            sort_finish = 1'b1;
            state_d     = f_layer ? ST_TX_START : ST_DUMP_PAR;
         end
         ST_DUMP_PAR: begin
            out_valid = 1'b1;
            if (last_word) begin
               state_d = ST_FILL;
               count_d = '0;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         ST_TX_START: begin
            tx_busy   = 1'b1;
            tx_line   = 1'b0;
            out_valid = (div_q == '0);
            div_d     = div_end ? '0 : div_q + DIV_ONE;
            if (div_end) begin
               state_d = ST_TX_DATA;
               bit_d   = '0;
            end
         end
         ST_TX_DATA: begin
            tx_busy = 1'b1;
            tx_line = out_word[bit_q];
            div_d   = div_end ? '0 : div_q + DIV_ONE;
            if (div_end) begin
               if (bit_q == BIT_LAST) begin
`ifdef SELF_TEST_PARITY_EN
                  state_d = ST_TX_PARITY;
`else
                  state_d = ST_TX_STOP;
`endif
               end else begin
                  bit_d = bit_q + BIT_ONE;
               end
            end
         end
`ifdef SELF_TEST_PARITY_EN
         ST_TX_PARITY: begin
            tx_busy = 1'b1;
            tx_line = ^out_word;
            div_d   = div_end ? '0 : div_q + DIV_ONE;
            if (div_end) state_d = ST_TX_STOP;
         end
`endif
         ST_TX_STOP: begin
            tx_busy = 1'b1;
            tx_line = 1'b1;
            div_d   = div_end ? '0 : div_q + DIV_ONE;
            if (div_end) begin
               if (last_word) begin
                  state_d = ST_FILL;
                  count_d = '0;
                  idx_d   = '0;
               end else begin
                  state_d = ST_TX_START;
                  idx_d   = idx_q + IDX_ONE;
               end
            end
         end
         default: state_d = ST_FILL;
      endcase

      // data_out keeps the last presented word between valid cycles.
      hold_d = out_valid ? out_word : hold_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FILL;
         count_q <= '0;
         idx_q   <= '0;
         bit_q   <= '0;
         div_q   <= '0;
         hold_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         hold_q  <= hold_d;
         mem_q   <= mem_d;
      end
   end

   assign count     = count_q;
   assign data_out  = out_valid ? out_word : hold_q;
   assign tx_out    = tx_line;
   assign dbg_state = state_q;
endmodule

// File: tb/tb_self_test_sort_tx.sv
// Directed and randomized checks of self_test_sort_tx against a queue-based stable-sort model.
module tb_self_test_sort_tx;
   localparam int DATA_W  = 32;
   localparam int BIT_DIV = 4;
`ifdef SELF_TEST_PARITY_EN
   localparam int FRAME_BITS = DATA_W + 3;
`else
   localparam int FRAME_BITS = DATA_W + 2;
`endif

   logic              clk = 1'b0;
   logic              rst, f_layer, in_valid, flush;
   logic [DATA_W-1:0] data_in;
   logic              in_ready, sort_finish, out_valid, tx_out, tx_busy;
   logic [2:0]        count;
   logic [2:0]        dbg_state;
   logic [DATA_W-1:0] data_out;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] model_q[$];
   logic [DATA_W-1:0] exp_q[$];

   self_test_sort_tx dut (
      .clk(clk), .rst(rst), .f_layer(f_layer), .data_in(data_in), .in_valid(in_valid),
      .in_ready(in_ready), .flush(flush), .count(count), .sort_finish(sort_finish),
      .data_out(data_out), .out_valid(out_valid), .tx_out(tx_out), .tx_busy(tx_busy),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int key_of(input logic [DATA_W-1:0] w);
      return int'((w >> 21) & 32'h1F);
   endfunction

   // Stable sort by key: repeatedly take the earliest-written word with the smallest key.
   task automatic build_expected();
      int best;
      exp_q.delete();
      while (model_q.size() > 0) begin
         best = 0;
         for (int j = 1; j < model_q.size(); j++)
            if (key_of(model_q[j]) < key_of(model_q[best])) best = j;
         exp_q.push_back(model_q[best]);
         model_q.delete(best);
      end
   endtask

   task automatic push(input logic [DATA_W-1:0] w, input logic fl);
      data_in  = w;
      in_valid = 1'b1;
      flush    = fl;
      chk("in_ready_fill", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      model_q.push_back(w);
      chk("count_after_push", count, model_q.size());
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic run_dump(input logic layer);
      logic [DATA_W-1:0] w;
      logic [DATA_W-1:0] last;
      logic              bitv;
      int n;
      build_expected();
      n = exp_q.size();
      last = '0;
      chk("count_at_done", count, n);
      chk("sort_finish_pulse", sort_finish, 1);
      chk("in_ready_done", in_ready, 0);
      in_valid = 1'b1;
      data_in  = $urandom;
      for (int k = 0; k < n; k++) begin
         w = exp_q.pop_front();
         last = w;
         if (!layer) begin
            @(negedge clk);
            f_layer = ~layer;
            chk("par_valid", out_valid, 1);
            chk("par_data", data_out, w);
            chk("par_in_ready", in_ready, 0);
            chk("par_sort_finish", sort_finish, 0);
         end else begin
            for (int b = 0; b < FRAME_BITS; b++) begin
               if (b == 0) bitv = 1'b0;
               else if (b <= DATA_W) bitv = w[b-1];
               else if (b == FRAME_BITS-1) bitv = 1'b1;
               else bitv = ^w;
               for (int c = 0; c < BIT_DIV; c++) begin
                  @(negedge clk);
                  f_layer = ~layer;
                  chk("ser_tx_out", tx_out, bitv);
                  chk("ser_busy", tx_busy, 1);
                  if (b == 0 && c == 0) begin
                     chk("ser_valid_first", out_valid, 1);
                     chk("ser_data", data_out, w);
                  end else begin
                     chk("ser_valid_other", out_valid, 0);
                  end
               end
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      f_layer  = layer;
      chk("end_out_valid", out_valid, 0);
      chk("end_tx_busy", tx_busy, 0);
      chk("end_tx_out", tx_out, 1);
      chk("end_count", count, 0);
      chk("end_in_ready", in_ready, 1);
      chk("end_data_hold", data_out, last);
      chk("end_sort_finish", sort_finish, 0);
   endtask

   initial begin
      int n;
      logic [DATA_W-1:0] w;
      rst = 1'b1; f_layer = 1'b0; in_valid = 1'b0; flush = 1'b0; data_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx_out", tx_out, 1);
      chk("rst_count", count, 0);
      chk("rst_sort_finish", sort_finish, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_tx_busy", tx_busy, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);

      // Parallel sort of keys 21, 1, 7, 2
      f_layer = 1'b0;
      push(32'hEAB6BAE1, 1'b0);
      push(32'hE822BEAF, 1'b0);
      push(32'hE8E8BEAF, 1'b0);
      push(32'hE842BEAF, 1'b0);
      run_dump(1'b0);

      // Flush on an empty buffer must not start a dump
      do_flush();
      chk("empty_flush_sf", sort_finish, 0);
      chk("empty_flush_ready", in_ready, 1);
      chk("empty_flush_count", count, 0);

      // Serial dump of keys 3 then 1
      f_layer = 1'b1;
      push(32'h0060_1234, 1'b0);
      push(32'h0020_ABCD, 1'b0);
      do_flush();
      run_dump(1'b1);

      // Equal keys keep write order
      f_layer = 1'b0;
      push(32'hC0000001, 1'b0);
      push(32'hC0000002, 1'b1);
      run_dump(1'b0);

      // Two held plus accept-with-flush gives three words
      push($urandom, 1'b0);
      push($urandom, 1'b0);
      push($urandom, 1'b1);
      run_dump(1'b0);

`ifdef SELF_TEST_PARITY_EN
      f_layer = 1'b1;
      push(32'h00000007, 1'b1);
      run_dump(1'b1);
`endif

      // Randomized rounds with narrow keys to force ties
      for (int r = 0; r < 8; r++) begin
         f_layer = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) begin
            w = $urandom;
            w[25:21] = 5'($urandom_range(0, 3));
            if (k == n-1 && n < 4 && $urandom_range(0, 1) == 1) push(w, 1'b1);
            else if (k == n-1 && n < 4) begin
               push(w, 1'b0);
               do_flush();
            end else push(w, 1'b0);
         end
         run_dump(f_layer);
      end

      // Reset during the start bit of a frame
      f_layer = 1'b1;
      push($urandom, 1'b0);
      push($urandom, 1'b1);
      chk("midrst_sf", sort_finish, 1);
      @(negedge clk);
      chk("midrst_start_bit", tx_out, 0);
      chk("midrst_busy_before", tx_busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_tx_out", tx_out, 1);
      chk("midrst_count", count, 0);
      chk("midrst_busy", tx_busy, 0);
      chk("midrst_out_valid", out_valid, 0);
      model_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 1);
      f_layer = 1'b0;
      push(32'h1234_5678, 1'b1);
      run_dump(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
